// File: rtl/rv_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rv_wb_arbiter
//   N-channel Wishbone B4 classic master arbiter. Several core request ports
//   share one Wishbone master bus. On each grant the arbiter registers the
//   winning channel's fields onto the bus. It then frames the transfer with
//   CYC/STB and routes the termination back to that channel only.
//
//   Arbitration is fixed priority (channel 0 highest) or round robin, chosen
//   by ROUND_ROBIN. Every transfer spends one IDLE cycle in arbitration and
//   at least one BUS cycle.
//
// Optional feature (macro RV_WB_TIMEOUT_EN):
//   If defined, a BUS cycle that gets no ack/err within TIMEOUT_CYCLES
//   cycles is terminated. The granted channel gets an o_err pulse in that
//   expiry cycle. If not defined, BUS waits indefinitely.
//
// Ports:
//   i_clk, i_reset_n    clock, asynchronous active-low reset
//   i_req/i_we          per-channel request / write enable
//   i_adr/i_wdat/i_sel  packed per-channel fields, channel k in slice k
//   o_ack/o_err         one-cycle termination pulses for the granted channel
//   o_rdata             bus read data passthrough, valid with o_ack
//   o_wb_*              registered Wishbone master outputs
//   i_wb_dat/ack/err    Wishbone slave responses
// ---------------------------------------------------------------------------
module rv_wb_arbiter #(
  parameter int CHANNELS       = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [CHANNELS-1:0]        i_req,
  input  logic [CHANNELS-1:0]        i_we,
  input  logic [CHANNELS*ADDR_W-1:0] i_adr,
  input  logic [CHANNELS*DATA_W-1:0] i_wdat,
  input  logic [CHANNELS*(DATA_W/8)-1:0] i_sel,
  output logic [CHANNELS-1:0]        o_ack,
  output logic [CHANNELS-1:0]        o_err,
  output logic [DATA_W-1:0]          o_rdata,
  output logic [ADDR_W-1:0]          o_wb_adr,
  output logic [DATA_W-1:0]          o_wb_dat,
  output logic                       o_wb_we,
  output logic [DATA_W/8-1:0]        o_wb_sel,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  input  logic [DATA_W-1:0]          i_wb_dat,
  input  logic                       i_wb_ack,
  input  logic                       i_wb_err
);

  localparam int SEL_W = DATA_W / 8;
  localparam int GW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state, next_state;
  logic [GW-1:0] grant;
  logic [GW-1:0] ptr;
  logic [GW-1:0] win;
  logic          any_req;
  logic          expire;
  logic          term;

  assign any_req = |i_req;
  assign term    = i_wb_ack | i_wb_err | expire;

  // CYC and STB come straight from the state register. They are always
  // equal, and an asynchronous reset drops them at once.
  assign o_wb_cyc = (state == BUS);
  assign o_wb_stb = (state == BUS);
  assign o_rdata  = i_wb_dat;

  // Winner selection. Round robin scans offsets CHANNELS..1 from the
  // pointer. The scan runs in reverse so that the nearest requester after
  // the pointer is assigned last and wins.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    if (ROUND_ROBIN != 0) begin
      for (int k = CHANNELS; k >= 1; k--) begin
        idx = (int'(ptr) + k) % CHANNELS;
        if (i_req[idx]) win = GW'(idx);
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (i_req[k]) win = GW'(k);
      end
    end
  end

`ifdef RV_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // The counter holds 0 in IDLE, so it enters BUS cleared. It then counts
  // BUS cycles that see no termination. It expires in the TIMEOUT_CYCLES-th
  // BUS cycle, which is when it would reach TIMEOUT_CYCLES.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!(i_wb_ack | i_wb_err)) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign expire = (state == BUS) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= next_state;
  end

  // Next state and per-channel termination pulses. Ack wins over err when
  // both arrive. A timeout only reports err when no ack arrives with it.
  always_comb begin
    next_state = state;
    o_ack      = '0;
    o_err      = '0;
    case (state)
      IDLE: begin
        if (any_req) next_state = BUS;
      end
      BUS: begin
        if (i_wb_ack)                 o_ack[grant] = 1'b1;
        else if (i_wb_err || expire)  o_err[grant] = 1'b1;
        if (term) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bus fields are captured only at grant time. Requester changes during
  // BUS therefore cannot disturb the transfer in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_adr <= '0;
      o_wb_dat <= '0;
      o_wb_sel <= '0;
      o_wb_we  <= 1'b0;
      grant    <= '0;
      ptr      <= GW'(CHANNELS - 1);
    end else if (state == IDLE && any_req) begin
      o_wb_adr <= i_adr[win*ADDR_W +: ADDR_W];
      o_wb_dat <= i_wdat[win*DATA_W +: DATA_W];
      o_wb_sel <= i_sel[win*SEL_W +: SEL_W];
      o_wb_we  <= i_we[win];
      grant    <= win;
      ptr      <= win;
    end
  end

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv_wb_arbiter
//   Self-checking bench for rv_wb_arbiter with two instances:
//   dut_a: CHANNELS=2, fixed priority
//   dut_b: CHANNELS=3, round robin, TIMEOUT_CYCLES=4
//   Expected grants go into a scoreboard queue when requests are driven.
//   They are popped and compared when the DUT pulses a termination.
//   Timeout checks are built only when RV_WB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_rv_wb_arbiter;

  typedef struct {
    logic [2:0]  mask;
    logic [31:0] adr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  exp_t sb[$];

  // dut_a signals
  logic [1:0]  a_req, a_we, a_ack, a_err;
  logic [63:0] a_adr, a_wdat;
  logic [7:0]  a_sel;
  logic [31:0] a_rdata, a_wb_adr, a_wb_dat, a_wb_rdat;
  logic        a_wb_we, a_cyc, a_stb, a_wb_ack, a_wb_err;
  logic [3:0]  a_wb_sel;

  // dut_b signals
  logic [2:0]  b_req, b_we, b_ack, b_err;
  logic [95:0] b_adr, b_wdat;
  logic [11:0] b_sel;
  logic [31:0] b_rdata, b_wb_adr, b_wb_dat, b_wb_rdat;
  logic        b_wb_we, b_cyc, b_stb, b_wb_ack, b_wb_err;
  logic [3:0]  b_wb_sel;

  rv_wb_arbiter #(.CHANNELS(2), .ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0),
                  .TIMEOUT_CYCLES(4)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(a_req), .i_we(a_we),
    .i_adr(a_adr), .i_wdat(a_wdat), .i_sel(a_sel), .o_ack(a_ack),
    .o_err(a_err), .o_rdata(a_rdata), .o_wb_adr(a_wb_adr),
    .o_wb_dat(a_wb_dat), .o_wb_we(a_wb_we), .o_wb_sel(a_wb_sel),
    .o_wb_cyc(a_cyc), .o_wb_stb(a_stb), .i_wb_dat(a_wb_rdat),
    .i_wb_ack(a_wb_ack), .i_wb_err(a_wb_err)
  );

  rv_wb_arbiter #(.CHANNELS(3), .ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1),
                  .TIMEOUT_CYCLES(4)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(b_req), .i_we(b_we),
    .i_adr(b_adr), .i_wdat(b_wdat), .i_sel(b_sel), .o_ack(b_ack),
    .o_err(b_err), .o_rdata(b_rdata), .o_wb_adr(b_wb_adr),
    .o_wb_dat(b_wb_dat), .o_wb_we(b_wb_we), .o_wb_sel(b_wb_sel),
    .o_wb_cyc(b_cyc), .o_wb_stb(b_stb), .i_wb_dat(b_wb_rdat),
    .i_wb_ack(b_wb_ack), .i_wb_err(b_wb_err)
  );

  task automatic wait_a_cyc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (a_cyc === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_b_cyc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (b_cyc === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req = '0; a_we = '0; a_adr = '0; a_wdat = '0; a_sel = '0;
    a_wb_rdat = '0; a_wb_ack = 1'b0; a_wb_err = 1'b0;
    b_req = '0; b_we = '0; b_adr = '0; b_wdat = '0; b_sel = '0;
    b_wb_rdat = '0; b_wb_ack = 1'b0; b_wb_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    compared++;
    if ({a_cyc, a_stb, a_wb_we, a_ack, a_err} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {a_cyc, a_stb, a_wb_we, a_ack, a_err});
    end
    compared++;
    if ({a_wb_adr, a_wb_dat, a_wb_sel} !== 68'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_fields: got %h expected 0", {a_wb_adr, a_wb_dat, a_wb_sel});
    end
    compared++;
    if ({b_cyc, b_stb, b_ack, b_err} !== 8'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_b: got %b expected 0", {b_cyc, b_stb, b_ack, b_err});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      compared++;
      if (a_cyc !== 1'b0 || b_cyc !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL idle_cyc: got %b%b expected 00", a_cyc, b_cyc);
      end
    end
    // terminations outside BUS must be ignored
    @(negedge clk); a_wb_ack = 1'b1; a_wb_err = 1'b1; #1;
    compared++;
    if ({a_ack, a_err} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_term: got %b expected 0000", {a_ack, a_err});
    end
    @(negedge clk); a_wb_ack = 1'b0; a_wb_err = 1'b0; #1;
    compared++;
    if (a_cyc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_term_cyc: got %b expected 0", a_cyc);
    end
  endtask

  task automatic test_fixed_priority();
    exp_t e;
    int last;
    for (int i = 0; i < 4; i++) begin
      e.mask = 3'b001; e.adr = 32'h1000_0000; sb.push_back(e);
    end
    @(negedge clk);
    a_adr = {32'h2000_0000, 32'h1000_0000}; a_we = 2'b00; a_req = 2'b11;
    last = -1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk); a_wb_ack = a_cyc; #1;
      compared++;
      if (a_cyc !== a_stb) begin
        mismatched++;
        $display("[TB] FAIL fp_cyc_stb: got cyc=%b stb=%b", a_cyc, a_stb);
      end
      if (a_ack !== 2'b00) begin
        e = sb.pop_front();
        compared++;
        if (a_ack !== e.mask[1:0]) begin
          mismatched++;
          $display("[TB] FAIL fp_ack: got %b expected %b", a_ack, e.mask[1:0]);
        end
        compared++;
        if (a_wb_adr !== e.adr) begin
          mismatched++;
          $display("[TB] FAIL fp_adr: got %h expected %h", a_wb_adr, e.adr);
        end
        if (last >= 0) begin
          compared++;
          if (c - last != 2) begin
            mismatched++;
            $display("[TB] FAIL fp_period: got %0d expected 2", c - last);
          end
        end
        last = c;
      end
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL fp_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk); a_req = 2'b00; a_wb_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int last;
    int bcnt;
    for (int i = 0; i < 6; i++) begin
      e.mask = 3'b001 << (i % 3);
      e.adr  = 32'h1000_0000 * (i % 3 + 1);
      sb.push_back(e);
    end
    @(negedge clk);
    b_adr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    b_we = 3'b000; b_req = 3'b111;
    last = -1; bcnt = 0;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (b_cyc) bcnt++; else bcnt = 0;
      b_wb_ack = (bcnt == 2);
      #1;
      if (b_ack !== 3'b000) begin
        e = sb.pop_front();
        compared++;
        if (b_ack !== e.mask) begin
          mismatched++;
          $display("[TB] FAIL rr_ack: got %b expected %b", b_ack, e.mask);
        end
        compared++;
        if (b_wb_adr !== e.adr) begin
          mismatched++;
          $display("[TB] FAIL rr_adr: got %h expected %h", b_wb_adr, e.adr);
        end
        if (last >= 0) begin
          compared++;
          if (c - last != 3) begin
            mismatched++;
            $display("[TB] FAIL rr_period: got %0d expected 3", c - last);
          end
        end
        last = c;
      end
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL rr_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk); b_req = 3'b000; b_wb_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_error_and_simultaneous();
    bit ok;
    @(negedge clk);
    a_adr = {32'h2000_0100, 32'h0000_0040};
    a_wdat = {32'h1111_2222, 32'hDEAD_BEEF};
    a_sel = 8'hF5; a_we = 2'b01; a_req = 2'b01;
    wait_a_cyc(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL err_grant: got cyc=0 expected 1");
    end
    compared++;
    if ({a_wb_we, a_wb_sel, a_wb_dat, a_wb_adr} !== {1'b1, 4'h5, 32'hDEAD_BEEF, 32'h0000_0040}) begin
      mismatched++;
      $display("[TB] FAIL write_fields: got %h expected %h",
               {a_wb_we, a_wb_sel, a_wb_dat, a_wb_adr},
               {1'b1, 4'h5, 32'hDEAD_BEEF, 32'h0000_0040});
    end
    a_adr[31:0] = 32'hFFFF_FFFF; a_wdat[31:0] = 32'h0; a_we = 2'b00;
    @(negedge clk); a_wb_err = 1'b1; #1;
    compared++;
    if ({a_wb_we, a_wb_dat, a_wb_adr} !== {1'b1, 32'hDEAD_BEEF, 32'h0000_0040}) begin
      mismatched++;
      $display("[TB] FAIL held_fields: got %h", {a_wb_we, a_wb_dat, a_wb_adr});
    end
    compared++;
    if ({a_ack, a_err} !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL err_only: got ack=%b err=%b expected ack=00 err=01", a_ack, a_err);
    end
    @(negedge clk); a_wb_err = 1'b0; a_req = 2'b00; #1;
    compared++;
    if (a_cyc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL err_drop: got cyc=%b expected 0", a_cyc);
    end
    @(negedge clk); a_req = 2'b10; a_we = 2'b00;
    wait_a_cyc(ok);
    compared++;
    if (!ok || a_wb_adr !== 32'h2000_0100 || a_wb_we !== 1'b0 || a_wb_sel !== 4'hF) begin
      mismatched++;
      $display("[TB] FAIL ch1_fields: got adr=%h we=%b sel=%h expected 20000100/0/f",
               a_wb_adr, a_wb_we, a_wb_sel);
    end
    a_wb_ack = 1'b1; a_wb_err = 1'b1; a_wb_rdat = 32'hCAFE_F00D; #1;
    compared++;
    if ({a_ack, a_err} !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL ack_wins: got ack=%b err=%b expected ack=10 err=00", a_ack, a_err);
    end
    compared++;
    if (a_rdata !== 32'hCAFE_F00D) begin
      mismatched++;
      $display("[TB] FAIL rdata: got %h expected cafef00d", a_rdata);
    end
    @(negedge clk); a_wb_ack = 1'b0; a_wb_err = 1'b0; a_req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    bit ok;
    @(negedge clk);
    b_adr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    b_req = 3'b010;
    wait_b_cyc(ok);
    b_req = 3'b000; b_adr[63:32] = 32'h0BAD_0BAD;
    @(negedge clk); b_wb_ack = 1'b1; #1;
    compared++;
    if (!ok || b_ack !== 3'b010 || b_wb_adr !== 32'h2000_0000) begin
      mismatched++;
      $display("[TB] FAIL req_drop: got ack=%b adr=%h expected 010/20000000", b_ack, b_wb_adr);
    end
    @(negedge clk); b_wb_ack = 1'b0;
    @(negedge clk); #1;
    compared++;
    if (b_cyc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL req_drop_idle: got cyc=%b expected 0", b_cyc);
    end
  endtask

  task automatic test_reset_mid_bus();
    bit ok;
    @(negedge clk);
    a_adr = {32'h2000_0100, 32'h0000_0080}; a_req = 2'b01;
    wait_a_cyc(ok);
    rst_n = 1'b0; a_wb_ack = 1'b1; #1;
    compared++;
    if (!ok || {a_cyc, a_stb, a_ack} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_bus: got cyc=%b stb=%b ack=%b expected 0", a_cyc, a_stb, a_ack);
    end
    @(negedge clk); rst_n = 1'b1; a_wb_ack = 1'b0;
    wait_a_cyc(ok);
    compared++;
    if (!ok || a_wb_adr !== 32'h0000_0080) begin
      mismatched++;
      $display("[TB] FAIL rearb: got cyc=%b adr=%h expected 1/00000080", a_cyc, a_wb_adr);
    end
    @(negedge clk); a_wb_ack = 1'b1; #1;
    compared++;
    if (a_ack !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL rearb_ack: got %b expected 01", a_ack);
    end
    @(negedge clk); a_wb_ack = 1'b0; a_req = 2'b00;
    @(negedge clk);
  endtask

`ifdef RV_WB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    @(negedge clk);
    b_adr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    b_req = 3'b001;
    wait_b_cyc(ok);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      compared++;
      if (!ok || b_err !== ((c == 4) ? 3'b001 : 3'b000) || b_ack !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL tmo_cycle%0d: got err=%b ack=%b", c, b_err, b_ack);
      end
    end
    @(negedge clk); b_req = 3'b000; #1;
    compared++;
    if (b_cyc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL tmo_drop: got cyc=%b expected 0", b_cyc);
    end
    @(negedge clk); b_req = 3'b001;
    wait_b_cyc(ok);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); b_wb_ack = 1'b1; #1;
    compared++;
    if (!ok || b_ack !== 3'b001 || b_err !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL tmo_ack_wins: got ack=%b err=%b expected 001/000", b_ack, b_err);
    end
    @(negedge clk); b_wb_ack = 1'b0; b_req = 3'b000;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_error_and_simultaneous();
    test_req_drop();
    test_reset_mid_bus();
`ifdef RV_WB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
